// File: rtl/cpu_pkg.sv
// cpu_pkg: ALU operation encodings, ALUOp codes, opcode/funct constants and the EX/MEM register layout.
package cpu_pkg;
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_NONE} alu_op_e;
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
    localparam logic [1:0] ALUOP_OPCODE = 2'b11;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_read;
        logic        mem_write;
        logic        branch_taken;
        logic [31:0] branch_target;
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [4:0]  write_reg;
    } ex_mem_t;
    // Undecoded funct/opcode values map to ALU_NONE, which the ALU turns into a zero result.
    function automatic alu_op_e alu_ctrl(input logic [1:0] alu_op, input logic [5:0] funct, input logic [5:0] opcode);
        alu_op_e f_op, o_op;
        f_op = funct == F_ADD ? ALU_ADD :
               funct == F_SUB ? ALU_SUB :
               funct == F_AND ? ALU_AND :
               funct == F_OR  ? ALU_OR  :
               funct == F_SLT ? ALU_SLT : ALU_NONE;
        o_op = opcode == OP_ADDI ? ALU_ADD :
               opcode == OP_ANDI ? ALU_AND :
               opcode == OP_ORI  ? ALU_OR  :
               opcode == OP_SLTI ? ALU_SLT : ALU_NONE;
        return alu_op == ALUOP_ADD   ? ALU_ADD :
               alu_op == ALUOP_SUB   ? ALU_SUB :
               alu_op == ALUOP_FUNCT ? f_op : o_op;
    endfunction
endpackage

// File: rtl/ex_mem_stage_alu.sv
// alu: 32-bit ADD/SUB/AND/OR/signed SLT with zero flag; ALU_NONE yields 0.
module alu
    import cpu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_e     op,
    output logic [31:0] result,
    output logic        zero
);
    always_comb begin
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {31'd0, $signed(a) < $signed(b)};
            default: result = '0;
        endcase
    end
    assign zero = result == '0;
endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX logic (ALU control, operand select, branch resolve) feeding the EX/MEM register.
// Define EX_FORWARDING_EN to forward rs/rt from EX/MEM first, then from WB.
module ex_mem_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite_in,
    input  logic        MemtoReg_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        RegDst_in,
    input  logic        ALUSrc_in,
    input  logic        Branch_in,
    input  logic [1:0]  ALUOp_in,
    input  logic [5:0]  opcode_in,
    input  logic [4:0]  rs_in,
    input  logic [4:0]  rt_in,
    input  logic [4:0]  rd_in,
    input  logic [31:0] pc_next_in,
    input  logic [31:0] read_data1_in,
    input  logic [31:0] read_data2_in,
    input  logic [31:0] sign_ext_in,
    input  logic        wb_RegWrite,
    input  logic [4:0]  wb_write_reg,
    input  logic [31:0] wb_write_data,
    input  logic        flush,
    input  logic        hold,
    output logic        RegWrite_out,
    output logic        MemtoReg_out,
    output logic        MemRead_out,
    output logic        MemWrite_out,
    output logic        branch_taken_out,
    output logic [31:0] branch_target_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] write_data_out,
    output logic [4:0]  write_reg_out
);
    ex_mem_t     ex_mem_q, ex_mem_d;
    logic [31:0] src_a, src_b, alu_b, alu_result;
    logic        alu_zero;
    alu_op_e     alu_op;
`ifdef EX_FORWARDING_EN
    // A load in EX/MEM has no data yet, so only non-load producers forward from there.
    function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] rf_val);
        return (src != '0 && ex_mem_q.reg_write && !ex_mem_q.mem_to_reg && ex_mem_q.write_reg == src) ? ex_mem_q.alu_result :
               (src != '0 && wb_RegWrite && wb_write_reg == src) ? wb_write_data : rf_val;
    endfunction
    assign src_a = fwd(rs_in, read_data1_in);
    assign src_b = fwd(rt_in, read_data2_in);
`else
    logic unused_fwd;
    assign unused_fwd = ^{wb_RegWrite, wb_write_reg, wb_write_data, rs_in};
    assign src_a = read_data1_in;
    assign src_b = read_data2_in;
`endif
    assign alu_b  = ALUSrc_in ? sign_ext_in : src_b;
    assign alu_op = alu_ctrl(ALUOp_in, sign_ext_in[5:0], opcode_in);
    alu u_alu (
        .a      (src_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result),
        .zero   (alu_zero)
    );
    assign ex_mem_d = '{
        reg_write:     RegWrite_in,
        mem_to_reg:    MemtoReg_in,
        mem_read:      MemRead_in,
        mem_write:     MemWrite_in,
        branch_taken:  Branch_in & ((opcode_in == OP_BEQ & alu_zero) | (opcode_in == OP_BNE & ~alu_zero)),
        branch_target: pc_next_in + (sign_ext_in << 2),
        alu_result:    alu_result,
        write_data:    src_b,
        write_reg:     RegDst_in ? rd_in : rt_in
    };
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_mem_q <= '0;
        end else if (flush) begin
            ex_mem_q.reg_write    <= 1'b0;
            ex_mem_q.mem_to_reg   <= 1'b0;
            ex_mem_q.mem_read     <= 1'b0;
            ex_mem_q.mem_write    <= 1'b0;
            ex_mem_q.branch_taken <= 1'b0;
        end else if (!hold) begin
            ex_mem_q <= ex_mem_d;
        end
    end
    assign RegWrite_out      = ex_mem_q.reg_write;
    assign MemtoReg_out      = ex_mem_q.mem_to_reg;
    assign MemRead_out       = ex_mem_q.mem_read;
    assign MemWrite_out      = ex_mem_q.mem_write;
    assign branch_taken_out  = ex_mem_q.branch_taken;
    assign branch_target_out = ex_mem_q.branch_target;
    assign alu_result_out    = ex_mem_q.alu_result;
    assign write_data_out    = ex_mem_q.write_data;
    assign write_reg_out     = ex_mem_q.write_reg;
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: scoreboard bench; a behavioural model predicts each EX/MEM update, a monitor compares after every edge.
module tb_ex_mem_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, RegDst_in, ALUSrc_in, Branch_in;
    logic [1:0]  ALUOp_in;
    logic [5:0]  opcode_in;
    logic [4:0]  rs_in, rt_in, rd_in;
    logic [31:0] pc_next_in, read_data1_in, read_data2_in, sign_ext_in;
    logic        wb_RegWrite;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic        flush, hold;
    logic        RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out, branch_taken_out;
    logic [31:0] branch_target_out, alu_result_out, write_data_out;
    logic [4:0]  write_reg_out;

    ex_mem_stage dut (
        .clk(clk), .reset(reset),
        .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .MemRead_in(MemRead_in),
        .MemWrite_in(MemWrite_in), .RegDst_in(RegDst_in), .ALUSrc_in(ALUSrc_in), .Branch_in(Branch_in),
        .ALUOp_in(ALUOp_in), .opcode_in(opcode_in), .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
        .pc_next_in(pc_next_in), .read_data1_in(read_data1_in), .read_data2_in(read_data2_in),
        .sign_ext_in(sign_ext_in), .wb_RegWrite(wb_RegWrite), .wb_write_reg(wb_write_reg),
        .wb_write_data(wb_write_data), .flush(flush), .hold(hold),
        .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out), .MemRead_out(MemRead_out),
        .MemWrite_out(MemWrite_out), .branch_taken_out(branch_taken_out),
        .branch_target_out(branch_target_out), .alu_result_out(alu_result_out),
        .write_data_out(write_data_out), .write_reg_out(write_reg_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        rw, m2r, mr, mw, bt;
        bit [31:0] tgt, alu, wd;
        bit [4:0]  wr;
        bit        known;
    } exp_t;

    exp_t m;
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit [31:0] model_fwd(input bit [4:0] src, input bit [31:0] rf);
`ifdef EX_FORWARDING_EN
        if (src != 0 && m.rw && !m.m2r && m.wr == src) return m.alu;
        if (src != 0 && wb_RegWrite && wb_write_reg == src) return wb_write_data;
`endif
        return rf;
    endfunction

    function automatic bit [31:0] slt(input bit [31:0] a, input bit [31:0] b);
        return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
    endfunction

    function automatic bit [31:0] model_alu(input bit [31:0] a, input bit [31:0] b);
        int f, o;
        f = int'(sign_ext_in[5:0]);
        o = int'(opcode_in);
        case (ALUOp_in)
            2'd0: return a + b;
            2'd1: return a - b;
            2'd2: return f == 32 ? a + b : f == 34 ? a - b : f == 36 ? (a & b) : f == 37 ? (a | b) : f == 42 ? slt(a, b) : 32'd0;
            default: return o == 8 ? a + b : o == 12 ? (a & b) : o == 13 ? (a | b) : o == 10 ? slt(a, b) : 32'd0;
        endcase
    endfunction

    function automatic void model_reset();
        m = '{default: 0};
        m.known = 1;
    endfunction

    // Predict the register contents after the coming edge, push it, then let the edge happen.
    task automatic step();
        bit [31:0] a, bb, r;
        if (flush) begin
            m.rw = 0; m.m2r = 0; m.mr = 0; m.mw = 0; m.bt = 0;
            m.known = 0;
        end else if (!hold) begin
            a  = model_fwd(rs_in, read_data1_in);
            bb = model_fwd(rt_in, read_data2_in);
            r  = model_alu(a, ALUSrc_in ? sign_ext_in : bb);
            m.rw = RegWrite_in; m.m2r = MemtoReg_in; m.mr = MemRead_in; m.mw = MemWrite_in;
            m.bt = Branch_in && ((opcode_in == 6'd4 && r == 0) || (opcode_in == 6'd5 && r != 0));
            m.tgt = pc_next_in + sign_ext_in * 4;
            m.alu = r;
            m.wd  = bb;
            m.wr  = RegDst_in ? rd_in : rt_in;
            m.known = 1;
        end
        sb.push_back(m);
        @(posedge clk);
        #2;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("RegWrite_out", 32'(RegWrite_out), 32'(e.rw));
                chk("MemtoReg_out", 32'(MemtoReg_out), 32'(e.m2r));
                chk("MemRead_out", 32'(MemRead_out), 32'(e.mr));
                chk("MemWrite_out", 32'(MemWrite_out), 32'(e.mw));
                chk("branch_taken_out", 32'(branch_taken_out), 32'(e.bt));
                if (e.known) begin
                    chk("branch_target_out", branch_target_out, e.tgt);
                    chk("alu_result_out", alu_result_out, e.alu);
                    chk("write_data_out", write_data_out, e.wd);
                    chk("write_reg_out", 32'(write_reg_out), 32'(e.wr));
                end
            end
        end
    end

    task automatic idle();
        {RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, RegDst_in, ALUSrc_in, Branch_in} = '0;
        ALUOp_in = 0; opcode_in = 0; rs_in = 0; rt_in = 0; rd_in = 0;
        pc_next_in = 0; read_data1_in = 0; read_data2_in = 0; sign_ext_in = 0;
        wb_RegWrite = 0; wb_write_reg = 0; wb_write_data = 0; flush = 0; hold = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " RegWrite_out"}, 32'(RegWrite_out), 0);
        chk({tag, " MemtoReg_out"}, 32'(MemtoReg_out), 0);
        chk({tag, " MemRead_out"}, 32'(MemRead_out), 0);
        chk({tag, " MemWrite_out"}, 32'(MemWrite_out), 0);
        chk({tag, " branch_taken_out"}, 32'(branch_taken_out), 0);
        chk({tag, " branch_target_out"}, branch_target_out, 0);
        chk({tag, " alu_result_out"}, alu_result_out, 0);
        chk({tag, " write_data_out"}, write_data_out, 0);
        chk({tag, " write_reg_out"}, 32'(write_reg_out), 0);
    endtask

    task automatic rtype(input bit [5:0] funct, input bit [4:0] rs, input bit [31:0] v1,
                         input bit [4:0] rt, input bit [31:0] v2, input bit [4:0] rd, input bit rw);
        idle();
        ALUOp_in = 2'b10; sign_ext_in = {26'd0, funct};
        rs_in = rs; read_data1_in = v1; rt_in = rt; read_data2_in = v2;
        RegDst_in = 1; rd_in = rd; RegWrite_in = rw;
    endtask

    task automatic rand_inputs();
        bit [5:0] ops [8];
        ops = '{6'd0, 6'd4, 6'd5, 6'd8, 6'd12, 6'd13, 6'd10, 6'd63};
        {RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, RegDst_in, ALUSrc_in, Branch_in} = 7'($urandom);
        ALUOp_in = 2'($urandom);
        opcode_in = ops[$urandom_range(0, 7)];
        rs_in = 5'($urandom_range(0, 7));
        rt_in = 5'($urandom_range(0, 7));
        rd_in = 5'($urandom_range(0, 7));
        pc_next_in = $urandom;
        read_data1_in = ($urandom_range(0, 3) == 0) ? read_data2_in : $urandom;
        read_data2_in = $urandom;
        sign_ext_in = ($urandom_range(0, 1) == 1) ? {$urandom_range(0, 1) == 1 ? 26'h3ffffff : 26'd0, 6'($urandom)}
                                                  : {26'h0000001, 6'($urandom_range(32, 42))};
        wb_RegWrite = 1'($urandom);
        wb_write_reg = 5'($urandom_range(0, 7));
        wb_write_data = $urandom;
        hold = ($urandom_range(0, 7) == 0);
        flush = ($urandom_range(0, 9) == 0);
    endtask

    initial begin
        reset = 1;
        idle();
        model_reset();
        #3;
        check_all_zero("reset");
        @(posedge clk);
        #2;
        reset = 0;
        // R-type ADD 5+7 -> r3
        rtype(6'b100000, 5'd5, 32'd5, 5'd7, 32'd7, 5'd3, 1);
        step();
        // BEQ taken / not taken
        idle();
        opcode_in = 6'b000100; ALUOp_in = 2'b01; Branch_in = 1;
        rs_in = 1; rt_in = 2; read_data1_in = 9; read_data2_in = 9;
        pc_next_in = 32'h100; sign_ext_in = 4;
        step();
        read_data2_in = 8;
        step();
        // BNE taken on inequality
        opcode_in = 6'b000101;
        step();
        // forwarding priority: EX/MEM beats WB
        rtype(6'b100000, 5'd5, 32'd5, 5'd6, 32'd7, 5'd3, 1);
        step();
        idle();
        ALUOp_in = 2'b01; rs_in = 3; read_data1_in = 0; rt_in = 0;
        wb_RegWrite = 1; wb_write_reg = 3; wb_write_data = 99;
        step();
        // previous RegWrite=0 -> WB value
        rtype(6'b100000, 5'd5, 32'd5, 5'd6, 32'd7, 5'd3, 0);
        step();
        idle();
        ALUOp_in = 2'b01; rs_in = 3; read_data1_in = 0; rt_in = 0;
        wb_RegWrite = 1; wb_write_reg = 3; wb_write_data = 99;
        step();
        // r0 is never forwarded
        rtype(6'b100000, 5'd5, 32'd5, 5'd6, 32'd7, 5'd0, 1);
        step();
        idle();
        ALUOp_in = 2'b00; rs_in = 0; read_data1_in = 5; rt_in = 0; read_data2_in = 1;
        wb_RegWrite = 1; wb_write_reg = 0; wb_write_data = 99;
        step();
        // hold for three edges, then flush together with hold
        idle();
        RegWrite_in = 1; MemRead_in = 1; MemWrite_in = 1; ALUOp_in = 0;
        read_data1_in = 32'h1234; read_data2_in = 32'h10; rt_in = 4;
        step();
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            flush = 0;
            hold = 1;
            step();
        end
        rand_inputs();
        hold = 1; flush = 1;
        step();
        // reset mid-stream with MemWrite_out set
        idle();
        MemWrite_in = 1; RegWrite_in = 1; read_data1_in = 7; read_data2_in = 3; rt_in = 2;
        step();
        #1;
        reset = 1;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(posedge clk);
        #2;
        reset = 0;
        rtype(6'b100010, 5'd1, 32'd50, 5'd2, 32'd8, 5'd4, 1);
        MemtoReg_in = 1;
        step();
        // SLT signedness
        rtype(6'b101010, 5'd10, 32'hffffffff, 5'd11, 32'd1, 5'd12, 1);
        step();
        rtype(6'b101010, 5'd10, 32'd1, 5'd11, 32'hffffffff, 5'd12, 1);
        step();
        // undecoded funct and opcode give 0
        rtype(6'b111111, 5'd1, 32'd3, 5'd2, 32'd4, 5'd5, 1);
        step();
        ALUOp_in = 2'b11; opcode_in = 6'b111111;
        step();
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            step();
        end
        idle();
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
